// File: rtl/axi_burst_writer.sv
// Command-driven AXI4 write master: splits an (addr, len) command into INCR bursts fed from a valid/ready stream.
// Latency: awvalid the cycle after command accept; W data is a combinational pass-through of the stream.
// Backpressure: stream stalls while wready is low; commands are refused (cmd_ready=0) while busy.
module axi_burst_writer #(
    parameter int G_DATAWIDTH = 32,
    parameter int G_ID_WIDTH  = 1,
    parameter int G_AXI_ID    = 0,
    parameter int G_MAX_BURST = 16
) (
    input  logic                   s_aclk,
    input  logic                   s_areset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [31:0]            cmd_addr,
    input  logic [15:0]            cmd_len,
    input  logic [G_DATAWIDTH-1:0] s_data,
    input  logic                   s_data_valid,
    output logic                   s_data_ready,
    output logic [G_ID_WIDTH-1:0]  m_axi_awid,
    output logic [31:0]            m_axi_awaddr,
    output logic [7:0]             m_axi_awlen,
    output logic [2:0]             m_axi_awsize,
    output logic [1:0]             m_axi_awburst,
    output logic                   m_axi_awvalid,
    input  logic                   m_axi_awready,
    output logic [G_DATAWIDTH-1:0] m_axi_wdata,
    output logic [3:0]             m_axi_wstrb,
    output logic                   m_axi_wlast,
    output logic                   m_axi_wvalid,
    input  logic                   m_axi_wready,
    input  logic [G_ID_WIDTH-1:0]  m_axi_bid,
    input  logic [1:0]             m_axi_bresp,
    input  logic                   m_axi_bvalid,
    output logic                   m_axi_bready,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_DONE} state_t;

    localparam logic [15:0] MAX_BEATS = 16'(G_MAX_BURST);

    state_t      state, state_nxt;
    logic        ready_en;
    logic [31:0] cur_addr;
    logic [15:0] remaining;
    logic [15:0] beat_cnt;
    logic [15:0] burst_beats;
    logic [15:0] beats;
    logic        unused_sig;

    // remaining is frozen while in AW, so awlen stays stable during an awready stall
    assign beats         = (remaining < MAX_BEATS) ? remaining : MAX_BEATS;
    assign m_axi_awid    = G_ID_WIDTH'(G_AXI_ID);
    assign m_axi_awaddr  = cur_addr;
    assign m_axi_awlen   = 8'(beats - 16'd1);
    assign m_axi_awsize  = 3'b010;
    assign m_axi_awburst = 2'b01;
    assign m_axi_wdata   = s_data;
    assign m_axi_wstrb   = 4'hF;
    assign busy          = (state != S_IDLE);
    assign unused_sig    = ^{m_axi_bid, cmd_addr[1:0]};

    always_ff @(posedge s_aclk) begin
        if (s_areset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cmd_ready     = 1'b0;
        m_axi_awvalid = 1'b0;
        m_axi_wvalid  = 1'b0;
        m_axi_wlast   = 1'b0;
        s_data_ready  = 1'b0;
        m_axi_bready  = 1'b0;
        done          = 1'b0;
        case (state)
            S_IDLE: begin
                // ready_en keeps cmd_ready low for the first cycle after reset
                cmd_ready = ready_en;
                if (cmd_valid && ready_en) begin
                    state_nxt = (cmd_len == 16'd0) ? S_DONE : S_AW;
                end
            end
            S_AW: begin
                m_axi_awvalid = 1'b1;
                if (m_axi_awready) begin
                    state_nxt = S_W;
                end
            end
            S_W: begin
                m_axi_wvalid = s_data_valid;
                s_data_ready = m_axi_wready;
                m_axi_wlast  = (beat_cnt == 16'd1);
                if (s_data_valid && m_axi_wready && (beat_cnt == 16'd1)) begin
                    state_nxt = S_B;
                end
            end
            S_B: begin
                m_axi_bready = 1'b1;
                if (m_axi_bvalid) begin
                    state_nxt = (remaining != 16'd0) ? S_AW : S_DONE;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge s_aclk) begin
        if (s_areset) begin
            ready_en    <= 1'b0;
            cur_addr    <= '0;
            remaining   <= '0;
            beat_cnt    <= '0;
            burst_beats <= '0;
            err         <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cur_addr  <= {cmd_addr[31:2], 2'b00};
                        remaining <= cmd_len;
                        err       <= 1'b0;
                    end
                end
                S_AW: begin
                    if (m_axi_awready) begin
                        beat_cnt    <= beats;
                        burst_beats <= beats;
                    end
                end
                S_W: begin
                    if (m_axi_wvalid && m_axi_wready) begin
                        beat_cnt  <= beat_cnt - 16'd1;
                        remaining <= remaining - 16'd1;
                    end
                end
                S_B: begin
                    if (m_axi_bvalid) begin
                        if (m_axi_bresp != 2'b00) begin
                            err <= 1'b1;
                        end
                        cur_addr <= cur_addr + {14'd0, burst_beats, 2'b00};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/axi_burst_writer.md
# axi_burst_writer

Command-driven AXI4 write master that takes a start address plus word count and a valid/ready data stream, and emits INCR write bursts. Sits directly upstream of the blk_mem_gen AXI memory slave and drives its AW/W/B channels so that stream producers (capture logic, DMA front-ends) can fill memory without knowing AXI. Commands longer than one burst are split into consecutive bursts automatically.

## Interface
- G_DATAWIDTH, 32, data and W-channel width; one word per beat; address step per beat is 4 bytes.
- G_ID_WIDTH, 1, width of m_axi_awid / m_axi_bid.
- G_AXI_ID, 0, constant value driven on m_axi_awid.
- G_MAX_BURST, 16, maximum beats per burst; legal range 1..256.
- s_aclk  in  1  clock; all logic rising-edge.
- s_areset  in  1  reset; one clock; reset is synchronous and active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_addr  in  32  start byte address; bits [1:0] ignored, treated as 0.
- cmd_len  in  16  number of words to write; 0 is legal.
- s_data  in  G_DATAWIDTH  stream data word.
- s_data_valid  in  1  stream word valid.
- s_data_ready  out  1  stream word consumed when s_data_valid && s_data_ready.
- m_axi_awid  out  G_ID_WIDTH  = G_AXI_ID.
- m_axi_awaddr  out  32  burst start address.
- m_axi_awlen  out  8  beats-1.
- m_axi_awsize  out  3  constant 3'b010.
- m_axi_awburst  out  2  constant 2'b01 (INCR).
- m_axi_awvalid / m_axi_awready  out / in  1  AW handshake.
- m_axi_wdata  out  G_DATAWIDTH  = s_data.
- m_axi_wstrb  out  4  constant 4'hF.
- m_axi_wlast  out  1  last beat of current burst.
- m_axi_wvalid / m_axi_wready  out / in  1  W handshake.
- m_axi_bid  in  G_ID_WIDTH  ignored.
- m_axi_bresp  in  2  write response.
- m_axi_bvalid / m_axi_bready  in / out  1  B handshake.
- busy  out  1  high from cmd accept until done.
- done  out  1  one-cycle pulse at command completion.
- err  out  1  sticky; set on any bresp != 0; cleared only by next cmd accept or reset.

## Operation
- States: IDLE, AW, W, B, DONE.
- IDLE: cmd_ready=1. On accept: latch addr (bits[1:0] cleared) into cur_addr, remaining=cmd_len, clear err; go to DONE if cmd_len==0, else AW.
- AW: beats = min(remaining, G_MAX_BURST); awaddr=cur_addr, awlen=beats-1, awvalid=1 held stable until awready; then beat_cnt=beats, go W.
- W: m_axi_wvalid = s_data_valid, s_data_ready = m_axi_wready (combinational pass-through, only in W); wlast = (beat_cnt==1). Each W handshake decrements beat_cnt and remaining. On handshake with wlast go B.
- B: bready=1. On bvalid: err |= (bresp!=0); cur_addr += beats*4 (32-bit wrap); remaining>0 → AW, else DONE.
- DONE: done=1 for exactly one cycle, busy=0 next; return IDLE.
- No 4 KB boundary splitting; command address ranges must not cross a 4 KB boundary within a burst (caller responsibility). Error does not abort remaining bursts.
- W never leads AW: wvalid only asserted after AW handshake.

## Timing
- Reset: cmd_ready=0, awvalid=0, wvalid=0, wlast=0, bready=0, s_data_ready=0, busy=0, done=0, err=0, state IDLE; cmd_ready rises the cycle after reset deasserts.
- Cmd accept at edge N → awvalid high in cycle N+1; cmd_len==0 → done high in cycle N+1, no AXI traffic.
- AW→W: first wvalid possible the cycle after AW handshake; W beats sustain 1/cycle when s_data_valid and wready both high.
- Last W handshake at edge M → bready high cycle M+1; B handshake at edge K → next awvalid (or done) in cycle K+1.
- AW outputs and awvalid must not change while awvalid=1 and awready=0.
- Reset mid-burst: all outputs return to reset values at the next edge; in-flight burst abandoned; the downstream slave must be reset together.
- cmd_valid while busy: ignored (cmd_ready=0), not queued.

## Test plan
- cmd addr 0x0, len 1, data 0xA5A5A5A5 → one burst awaddr 0x0 awlen 0, single beat with wlast, done pulse; memory read back 0xA5A5A5A5.
- G_MAX_BURST=16, cmd addr 0x100, len 40, data 0..39 → bursts awaddr 0x100/0x140/0x180, awlen 15/15/7, wlast on beats 16/32/40; one done; readback word i = i.
- Same as above with s_data_valid toggling randomly and bvalid delayed 5 cycles → identical memory contents, no dropped/duplicated beats, awvalid stable while stalled.
- cmd len 0 → done in cycle after accept, awvalid never asserted, busy high exactly 1 cycle.
- Slave model returns bresp=2'b10 on burst 2 of 3 → err set and held, all 3 bursts still issued, err cleared on next cmd accept.
- s_areset asserted mid-W of a 16-beat burst → next edge all outputs at reset values; new len-4 cmd then completes normally.
